// File: rtl/ram_dump_uart.sv
// Sweeps RAM port B addresses 0..DEPTH-1, waits out the read latency, and sends
// each byte as an 8N1 UART frame (LSB first). It is the readback path to a host.
//
// state   | meaning
// IDLE    | waiting for start; tx high
// ADDR    | address_b presented to the RAM for one cycle
// WAIT    | RD_LAT cycles of RAM read latency
// LOAD    | q_b captured into the shift register
// START   | start bit (tx low) for BAUD_DIV cycles
// DATA    | 8 data bits, BAUD_DIV cycles each, LSB first
// STOP    | stop bit (tx high) for BAUD_DIV cycles
// NEXT    | advance the address or finish the sweep
// DONE    | one-cycle done pulse; address returns to 0
module ram_dump_uart #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        q_b,
  output logic [ADDR_W-1:0] address_b,
  output logic              wren_b,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_DIV + 4);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WAIT, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               tx_q, tx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
    end
  end

  // One counter serves both the latency wait and the baud timer; it is
  // cleared on every state entry and at every data-bit boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_ADDR;
          addr_d  = '0;
        end
      end
      S_ADDR: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        shift_d = q_b;
        state_d = S_START;
        cnt_d   = '0;
      end
      S_START: begin
        if (cnt_q == BAUD_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          state_d = S_NEXT;
          cnt_d   = '0;
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (addr_q == ADDR_LAST) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_ADDR;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // tx is registered from the next state so it switches exactly on the boundary
    tx_d = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shift_d[0];
  end

  always_comb begin
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    done      = (state_q == S_DONE);
    address_b = addr_q;
    wren_b    = 1'b0;
    tx        = tx_q;
  end

endmodule

// File: tb/tb_ram_dump_uart.sv
// Directed bench: four dumper instances (DEPTH 1/4, RD_LAT 1/2/3) at BAUD_DIV=10,
// each fed by a latency-matched RAM model; a per-cycle UART decoder checks frames.
module tb_ram_dump_uart;

  logic       clk;
  logic       rst_n;
  logic       start_r [4];
  logic [3:0] addr_w  [4];
  logic       wren_w  [4];
  logic       tx_w    [4];
  logic       busy_w  [4];
  logic       done_w  [4];
  logic [7:0] mem     [4][4];

  int n_err = 0;
  int n_chk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DEP = (g == 0) ? 1 : 4;
    localparam int LAT = (g == 2) ? 1 : ((g == 3) ? 3 : 2);
    logic [7:0] pipe [3];

    ram_dump_uart #(
      .CLK_FREQ(1000), .BAUD(100), .ADDR_W(4), .DEPTH(DEP), .RD_LAT(LAT)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_r[g]), .q_b(pipe[LAT-1]),
      .address_b(addr_w[g]), .wren_b(wren_w[g]), .tx(tx_w[g]),
      .busy(busy_w[g]), .done(done_w[g])
    );

    always @(posedge clk) begin
      pipe[0] <= mem[g][addr_w[g][1:0]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] q_bytes [$];
  int adr_seq [$];
  int done_k, done_cnt, wren_bad, overlap, busy_after, adr_after;
  int first_fall, tx_bad, glitch, frame_bad;

  // Pulses (or holds) start on instance idx and observes every cycle at negedge.
  // k counts cycles after the edge that accepted start.
  task automatic run_dump(input int idx, input int pulse_at, input bit hold);
    int k, ph, last_adr;
    bit in_fr, lvl, exp_tx;
    logic [7:0] sh, sf;
    sf = 8'hA5;
    q_bytes.delete(); adr_seq.delete();
    done_k = -1; done_cnt = 0; wren_bad = 0; overlap = 0;
    busy_after = -1; adr_after = -1; first_fall = -1;
    tx_bad = 0; glitch = 0; frame_bad = 0;
    in_fr = 0; ph = 0; lvl = 1; sh = '0; last_adr = -1;
    @(negedge clk); start_r[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk); if (!hold) start_r[idx] = 1'b0;
    for (k = 0; k < 1000; k++) begin
      if (int'(addr_w[idx]) != last_adr) begin
        last_adr = int'(addr_w[idx]);
        adr_seq.push_back(last_adr);
      end
      if (wren_w[idx] !== 1'b0) wren_bad++;
      if (busy_w[idx] && done_w[idx]) overlap++;
      if (done_w[idx]) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (idx == 0) begin
        if (k < 4)       exp_tx = 1'b1;
        else if (k < 14) exp_tx = 1'b0;
        else if (k < 94) exp_tx = sf[(k-14)/10];
        else             exp_tx = 1'b1;
        if (tx_w[idx] !== exp_tx) tx_bad++;
      end
      if (!in_fr) begin
        if (tx_w[idx] == 1'b0) begin
          in_fr = 1; ph = 0;
          if (first_fall < 0) first_fall = k;
        end
      end else begin
        ph++;
      end
      if (in_fr) begin
        if (ph % 10 == 0) lvl = tx_w[idx];
        else if (tx_w[idx] !== lvl) glitch++;
        if (ph % 10 == 5) begin
          if (ph / 10 == 0) begin
            if (tx_w[idx] !== 1'b0) frame_bad++;
          end else if (ph / 10 <= 8) begin
            sh[ph/10 - 1] = tx_w[idx];
          end else begin
            if (tx_w[idx] !== 1'b1) frame_bad++;
            q_bytes.push_back(sh);
          end
        end
        if (ph == 99) in_fr = 0;
      end
      if (k == pulse_at) start_r[idx] = 1'b1;
      if (k == pulse_at + 1 && !hold) start_r[idx] = 1'b0;
      if (done_k >= 0 && k == done_k + 2) begin
        busy_after = int'(busy_w[idx]);
        adr_after  = int'(addr_w[idx]);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_sweep(input string tag, input int exp_done_k);
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C; exp_b[3] = 8'h81;
    chk({tag, "_nbytes"}, q_bytes.size(), 4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s_byte%0d", tag, j),
          (j < q_bytes.size()) ? int'(q_bytes[j]) : -1, int'(exp_b[j]));
    chk({tag, "_done_k"}, done_k, exp_done_k);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_frame_bad"}, frame_bad + glitch, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) start_r[i] = 1'b1;
    mem[0][0] = 8'hA5; mem[0][1] = 8'h00; mem[0][2] = 8'h00; mem[0][3] = 8'h00;
    for (int i = 1; i < 4; i++) begin
      mem[i][0] = 8'h00; mem[i][1] = 8'hFF; mem[i][2] = 8'h3C; mem[i][3] = 8'h81;
    end

    // reset holds outputs even with start high
    repeat (3) @(negedge clk);
    chk("rst_tx",   int'(tx_w[1]),   1);
    chk("rst_busy", int'(busy_w[1]), 0);
    chk("rst_done", int'(done_w[1]), 0);
    chk("rst_addr", int'(addr_w[1]), 0);
    chk("rst_wren", int'(wren_w[1]), 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_first_busy", int'(busy_w[1]), 1);
    chk("rst_first_addr", int'(addr_w[1]), 0);
    for (int i = 0; i < 4; i++) start_r[i] = 1'b0;
    pulse_reset();

    // single frame, DEPTH=1, byte A5
    run_dump(0, -1, 1'b0);
    chk("sf_nbytes", q_bytes.size(), 1);
    chk("sf_byte", (q_bytes.size() > 0) ? int'(q_bytes[0]) : -1, 8'hA5);
    chk("sf_tx_bad_cycles", tx_bad, 0);
    chk("sf_first_fall", first_fall, 4);
    chk("sf_done_k", done_k, 105);
    chk("sf_done_cnt", done_cnt, 1);
    chk("sf_overlap", overlap, 0);

    // full sweep with an ignored start pulse during word 2
    run_dump(1, 250, 1'b0);
    check_sweep("sweep", 420);
    chk("sweep_adr_n", adr_seq.size(), 5);
    for (int j = 0; j < 5; j++)
      chk($sformatf("sweep_adr%0d", j),
          (j < adr_seq.size()) ? adr_seq[j] : -1, (j == 4) ? 0 : j);
    chk("sweep_wren", wren_bad, 0);
    chk("sweep_overlap", overlap, 0);
    chk("sweep_no_requeue", busy_after, 0);

    // start held high re-triggers right after done
    run_dump(1, -1, 1'b1);
    chk("hold_done_k", done_k, 420);
    chk("hold_retrigger_busy", busy_after, 1);
    chk("hold_retrigger_addr", adr_after, 0);
    start_r[1] = 1'b0;
    pulse_reset();

    // reset during DATA bit 3 of word 1
    @(negedge clk); start_r[1] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_r[1] = 1'b0;
    repeat (152) @(negedge clk);
    chk("rmf_pre_addr", int'(addr_w[1]), 1);
    chk("rmf_pre_busy", int'(busy_w[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("rmf_tx",   int'(tx_w[1]),   1);
    chk("rmf_busy", int'(busy_w[1]), 0);
    chk("rmf_addr", int'(addr_w[1]), 0);
    @(negedge clk); rst_n = 1'b1;
    run_dump(1, -1, 1'b0);
    check_sweep("rmf_restart", 420);

    // read latency variants: per-word period shifts by one cycle
    run_dump(2, -1, 1'b0);
    check_sweep("lat1", 416);
    run_dump(3, -1, 1'b0);
    check_sweep("lat3", 424);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
